// File: rtl/cpu_prefetch_queue.sv
// Purpose : sequential instruction prefetch buffer between instruction memory and the fetch stage.
// Latency : a word acked by memory is visible at the head one cycle after the ack (push latency 1).
// Backpre.: a new request is issued only when a FIFO slot is reserved for it; i_ready=0 stalls memory reads.
//
// Ports
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_flush, i_flush_pc         redirect: empty the queue and restart fetching at i_flush_pc
//   o_mem_req, o_mem_addr       registered single-outstanding read request to instruction memory
//   i_mem_ack, i_mem_data       read completion and returned instruction word
//   o_valid, o_instruction,     queue head (combinational from storage); NOP/0 when empty
//   o_pc, i_ready               head is popped on o_valid & i_ready
module cpu_prefetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_flush_pc,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_ack,
   input  logic [XLEN-1:0] i_mem_data,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_ready
);

   localparam int unsigned     PW  = $clog2(DEPTH);
   localparam int unsigned     CW  = PW + 1;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   // DRAIN: a request issued before a flush is still in flight; its data must be thrown away
   typedef enum logic {
      ST_FETCH,
      ST_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic            mem_req_q, mem_req_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

   logic [XLEN-1:0] ins_mem [DEPTH];
   logic [XLEN-1:0] pc_mem  [DEPTH];

   logic ack;
   logic push;
   logic pop;
   logic head_vld;

   assign ack      = i_mem_ack & mem_req_q;   // acks without a request are ignored
   assign head_vld = (count_q != '0);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;
      pop        = 1'b0;

      if (i_flush) begin
         // flush beats push and pop: queue emptied, any ack data this cycle is dropped
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = i_flush_pc;
         if (!mem_req_q || ack) begin
            mem_req_d  = 1'b1;
            mem_addr_d = i_flush_pc;
            state_d    = ST_FETCH;
         end else begin
            // old request still pending: keep its address stable and wait for its ack
            state_d = ST_DRAIN;
         end
      end else if (state_q == ST_DRAIN) begin
         if (ack) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = ST_FETCH;
         end
      end else begin
         push    = ack;
         pop     = head_vld & i_ready;
         count_d = count_q + CW'(push) - CW'(pop);
         if (push) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         // a pending unacked request keeps its slot reserved; otherwise only issue
         // when the word it returns is guaranteed a free entry
         if (!(mem_req_q && !ack)) begin
            mem_req_d  = (count_d < CW'(DEPTH));
            mem_addr_d = fetch_pc_d;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // storage needs no reset: entries are only observed while counted valid
   always_ff @(posedge i_clk) begin
      if (push) begin
         ins_mem[wr_ptr_q] <= i_mem_data;
         pc_mem[wr_ptr_q]  <= mem_addr_q;
      end
   end

   assign o_mem_req     = mem_req_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_valid       = head_vld;
   assign o_instruction = head_vld ? ins_mem[rd_ptr_q] : NOP;
   assign o_pc          = head_vld ? pc_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_cpu_prefetch_queue.sv
// Purpose : self-checking bench for cpu_prefetch_queue (queue model + directed scenarios).
// Latency : memory responder acks after a programmable number of request cycles.
// Backpre.: consumer ready driven per scenario.
module tb_cpu_prefetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          DEP = 4;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_flush = 1'b0;
   logic [31:0] i_flush_pc = '0;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_data = '0;
   logic        o_valid;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
   logic        i_ready = 1'b0;

   // second instance: top-of-address-space start, always-ready memory and consumer
   logic        w_flush = 1'b0;
   logic [31:0] w_flush_pc = '0;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack = 1'b0;
   logic [31:0] w_data = '0;
   logic        w_valid;
   logic [31:0] w_ins;
   logic [31:0] w_pc;
   logic        w_ready = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int lat   = 1;

   always #5 i_clk = ~i_clk;

   cpu_prefetch_queue u_dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
      .i_mem_data(i_mem_data), .o_valid(o_valid), .o_instruction(o_instruction),
      .o_pc(o_pc), .i_ready(i_ready)
   );

   cpu_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(w_flush), .i_flush_pc(w_flush_pc),
      .o_mem_req(w_req), .o_mem_addr(w_addr), .i_mem_ack(w_ack),
      .i_mem_data(w_data), .o_valid(w_valid), .o_instruction(w_ins),
      .o_pc(w_pc), .i_ready(w_ready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin : responder
      int age;
      age = 0;
      forever begin
         @(negedge i_clk);
         #1;
         if (!i_reset_n || !o_mem_req) begin
            age       = 0;
            i_mem_ack = 1'b0;
         end else begin
            // an ack in the previous cycle closed that request; this one is new
            age       = i_mem_ack ? 1 : age + 1;
            i_mem_ack = (age >= lat);
         end
         i_mem_data = i_mem_ack ? mem_word(o_mem_addr) : 32'hDEAD_BEEF;
         w_ack      = i_reset_n && w_req;
         w_data     = ~w_addr;
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        m_q[$];
   logic        m_req   = 1'b0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_fpc   = '0;
   logic        m_drain = 1'b0;
   logic        m_ack;
   ent_t        m_e;

   initial begin : model
      forever begin
         @(posedge i_clk or negedge i_reset_n);
         if (!i_reset_n) begin
            m_q.delete();
            m_req   = 1'b0;
            m_addr  = '0;
            m_fpc   = '0;
            m_drain = 1'b0;
         end else begin
            m_ack = i_mem_ack && m_req;
            if (i_flush) begin
               m_q.delete();
               m_fpc = i_flush_pc;
               if (!m_req || m_ack) begin
                  m_req   = 1'b1;
                  m_addr  = i_flush_pc;
                  m_drain = 1'b0;
               end else begin
                  m_drain = 1'b1;
               end
            end else if (m_drain) begin
               if (m_ack) begin
                  m_req   = 1'b1;
                  m_addr  = m_fpc;
                  m_drain = 1'b0;
               end
            end else begin
               if (m_q.size() > 0 && i_ready) void'(m_q.pop_front());
               if (m_ack) begin
                  m_e.pc  = m_addr;
                  m_e.ins = i_mem_data;
                  m_q.push_back(m_e);
                  m_fpc = m_fpc + 32'd4;
               end
               if (!(m_req && !m_ack)) begin
                  m_req  = (m_q.size() < DEP);
                  m_addr = m_fpc;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      forever begin
         @(negedge i_clk);
         chk("m_valid", 32'(o_valid), 32'(m_q.size() > 0));
         chk("m_pc",    o_pc,          (m_q.size() > 0) ? m_q[0].pc  : 32'h0);
         chk("m_ins",   o_instruction, (m_q.size() > 0) ? m_q[0].ins : NOP);
         chk("m_req",   32'(o_mem_req), 32'(m_req));
         chk("m_addr",  o_mem_addr,    m_addr);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      i_reset_n = 1'b0;
      i_flush   = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int found;
      lat     = 1;
      i_ready = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("rst_req",   32'(o_mem_req), 32'h0);
      chk("rst_addr",  o_mem_addr, 32'h0);
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_ins",   o_instruction, NOP);
      chk("rst_pc",    o_pc, 32'h0);
      chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
      i_reset_n = 1'b1;

      // fast memory, consumer always ready; wrap instance runs alongside
      for (int k = 1; k <= 4; k++) begin
         @(negedge i_clk);
         if (k <= 3) begin
            chk("t1_addr", o_mem_addr, 32'(4 * (k - 1)));
            chk("t6_addr", w_addr, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
         end
         chk("t1_valid", 32'(o_valid), 32'(k >= 2));
         if (k >= 2) begin
            chk("t1_pc",  o_pc, 32'(4 * (k - 2)));
            chk("t1_ins", o_instruction, mem_word(32'(4 * (k - 2))));
            chk("t6_pc",  w_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
            chk("t6_ins", w_ins, ~(32'hFFFF_FFF8 + 32'(4 * (k - 2))));
         end
      end
      repeat (12) @(negedge i_clk);

      // consumer stalled: queue fills to 4 words, request stops
      i_ready = 1'b0;
      do_reset();
      repeat (8) @(negedge i_clk);
      chk("t2_req_off", 32'(o_mem_req), 32'h0);
      chk("t2_valid",   32'(o_valid), 32'h1);
      chk("t2_head",    o_pc, 32'h0);
      chk("t2_idle_addr", o_mem_addr, 32'h10);
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("t2_rereq",   32'(o_mem_req), 32'h1);
      chk("t2_readdr",  o_mem_addr, 32'h10);
      for (int k = 1; k <= 4; k++) begin
         chk("t2_order", o_pc, 32'(4 * k));
         @(negedge i_clk);
      end
      repeat (6) @(negedge i_clk);

      // slow memory, flush while a request is pending -> drain
      lat = 3;
      do_reset();
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
         @(negedge i_clk);
         if (o_mem_req && o_mem_addr == 32'h8) found = 1;
      end
      chk("t3_reach", 32'(found), 32'h1);
      @(negedge i_clk);
      i_flush    = 1'b1;
      i_flush_pc = 32'h100;
      @(negedge i_clk);
      i_flush = 1'b0;
      chk("t3_hold_req",  32'(o_mem_req), 32'h1);
      chk("t3_hold_addr", o_mem_addr, 32'h8);
      chk("t3_flushed",   32'(o_valid), 32'h0);
      @(negedge i_clk);
      chk("t3_new_addr",  o_mem_addr, 32'h100);
      chk("t3_drop",      32'(o_valid), 32'h0);
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge i_clk);
         if (o_valid) found = 1;
      end
      chk("t3_got_valid", 32'(found), 32'h1);
      chk("t3_first_pc",  o_pc, 32'h100);
      repeat (6) @(negedge i_clk);

      // flush coincident with ack and pop, two entries queued
      lat     = 1;
      i_ready = 1'b0;
      do_reset();
      repeat (3) @(negedge i_clk);
      chk("t4_pre_valid", 32'(o_valid), 32'h1);
      chk("t4_pre_addr",  o_mem_addr, 32'h8);
      i_flush    = 1'b1;
      i_flush_pc = 32'h200;
      i_ready    = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      chk("t4_empty", 32'(o_valid), 32'h0);
      chk("t4_req",   32'(o_mem_req), 32'h1);
      chk("t4_addr",  o_mem_addr, 32'h200);
      @(negedge i_clk);
      chk("t4_no_drain", 32'(o_valid), 32'h1);
      chk("t4_pc",       o_pc, 32'h200);
      repeat (4) @(negedge i_clk);

      // reset in the middle of an outstanding request
      lat = 1;
      do_reset();
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
         @(negedge i_clk);
         if (o_mem_req && o_mem_addr == 32'h20) begin
            found = 1;
            lat   = 100;
         end
      end
      chk("t5_reach", 32'(found), 32'h1);
      @(negedge i_clk);
      chk("t5_pending", o_mem_addr, 32'h20);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("t5_req",   32'(o_mem_req), 32'h0);
      chk("t5_addr",  o_mem_addr, 32'h0);
      chk("t5_valid", 32'(o_valid), 32'h0);
      chk("t5_ins",   o_instruction, NOP);
      chk("t5_pc",    o_pc, 32'h0);
      lat = 1;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      chk("t5_restart_req",  32'(o_mem_req), 32'h1);
      chk("t5_restart_addr", o_mem_addr, 32'h0);
      repeat (6) @(negedge i_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
